// File: rtl/param_update_scheduler.sv
// Queues host parameter writes on clk and applies them to the register bank only on
// sim_clk rising boundaries, a bounded number per step.
module param_update_scheduler #(
  parameter int NP           = 8,
  parameter int AW           = 4,
  parameter int DEPTH        = 8,
  parameter int MAX_PER_TICK = 4,
  parameter logic [NP*32-1:0] RESET_VALUES = {{(NP-4)*32{1'b0}}, 32'd1024, {96{1'b0}}}
) (
  input  logic                       clk,
  input  logic                       reset_global,
  input  logic                       sim_clk,
  input  logic                       wr_stb,
  input  logic [AW-1:0]              wr_addr,
  input  logic [31:0]                wr_data,
  input  logic                       clear_status,
  output logic [NP*32-1:0]           param_bus,
  output logic [NP-1:0]              update_pulse,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       fifo_full,
  output logic                       overflow,
  output logic                       bad_addr,
  output logic                       busy
);
  // state | meaning
  // IDLE  | waiting for a sim_clk tick with queued writes
  // DRAIN | popping one entry per cycle until empty or burst limit reached

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(MAX_PER_TICK + 1);
  localparam int EW = AW + 32;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3, tick;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level, level_nxt;
  logic [BW-1:0]     burst_cnt;
  logic [AW-1:0]     head_addr;
  logic [31:0]       head_data;
  logic              pop, push, last_pop, head_idx_ok;
  logic              ovf_set, bad_set;
  logic [NP*32-1:0]  param_q;
  logic [NP-1:0]     pulse_q;
  logic              ovf_q, bad_q;

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sim_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick        = s2 & ~s3;
  assign fifo_full   = (level == LW'(DEPTH));
  assign push        = wr_stb & (~fifo_full | pop);
  assign level_nxt   = level + LW'(push) - LW'(pop);
  assign {head_addr, head_data} = mem[rd_ptr];
  assign head_idx_ok = (32'(head_addr) < NP);
  // a concurrent push keeps the burst going if the limit has not been reached
  assign last_pop    = (burst_cnt + BW'(1) == BW'(MAX_PER_TICK)) || (level_nxt == '0);
  assign ovf_set     = wr_stb & fifo_full & ~pop;
  assign bad_set     = pop & ~head_idx_ok;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_addr, wr_data};
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick && level != '0) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    busy = 1'b0;
    if (state == DRAIN) begin
      pop  = 1'b1;
      busy = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
    end else if (pop) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      param_q <= RESET_VALUES;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (pop && head_idx_ok) begin
        for (int i = 0; i < NP; i++) begin
          if (head_addr == AW'(i)) begin
            param_q[i*32 +: 32] <= head_data;
            pulse_q[i]          <= 1'b1;
          end
        end
      end
    end
  end

  // a new error in the same cycle as clear_status keeps the flag set
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      ovf_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      if (ovf_set)           ovf_q <= 1'b1;
      else if (clear_status) ovf_q <= 1'b0;
      if (bad_set)           bad_q <= 1'b1;
      else if (clear_status) bad_q <= 1'b0;
    end
  end

  assign param_bus    = param_q;
  assign update_pulse = pulse_q;
  assign fifo_level   = level;
  assign overflow     = ovf_q;
  assign bad_addr     = bad_q;

endmodule

// File: tb/tb_param_update_scheduler.sv
// Bench for param_update_scheduler: directed scenarios plus random write bursts,
// checked against a queue-based model of the parameter bank.
module tb_param_update_scheduler;
  localparam int NP    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int MAXPT = 4;

  logic              clk, reset_global, sim_clk, wr_stb, clear_status;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic [NP*32-1:0]  param_bus;
  logic [NP-1:0]     update_pulse;
  logic [$clog2(DEPTH):0] fifo_level;
  logic              fifo_full, overflow, bad_addr, busy;

  param_update_scheduler dut (
    .clk(clk), .reset_global(reset_global), .sim_clk(sim_clk),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_status(clear_status), .param_bus(param_bus),
    .update_pulse(update_pulse), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .overflow(overflow), .bad_addr(bad_addr),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_param [NP];
  logic        m_ovf, m_bad;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NP; i++) m_param[i] = (i == 3) ? 32'd1024 : 32'd0;
    mq.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NP; i++)
      check_val($sformatf("%s slot%0d", tag, i), param_bus[i*32 +: 32], m_param[i]);
    check_val({tag, " level"}, 32'(fifo_level), 32'(mq.size()));
    check_val({tag, " full"}, 32'(fifo_full), 32'(mq.size() == DEPTH));
    check_val({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, " bad_addr"}, 32'(bad_addr), 32'(m_bad));
    check_val({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // called at a negedge; returns at the following negedge
  task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] d, input bit clr);
    ent_t e;
    wr_stb       = 1'b1;
    wr_addr      = a;
    wr_data      = d;
    clear_status = clr;
    @(negedge clk);
    wr_stb       = 1'b0;
    clear_status = 1'b0;
    e.a = a;
    e.d = d;
    if (mq.size() < DEPTH) begin
      mq.push_back(e);
      if (clr) m_ovf = 1'b0;
    end else begin
      m_ovf = 1'b1;
    end
    if (clr) m_bad = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    m_ovf = 1'b0;
    m_bad = 1'b0;
  endtask

  // one sim_clk period: model applies up to MAXPT queued writes in order
  task automatic do_tick(input string tag);
    logic [NP-1:0] seen, exp_mask;
    ent_t e;
    int n;
    exp_mask = '0;
    seen     = '0;
    n = (mq.size() < MAXPT) ? mq.size() : MAXPT;
    for (int k = 0; k < n; k++) begin
      e = mq.pop_front();
      if (32'(e.a) < NP) begin
        m_param[e.a] = e.d;
        exp_mask[e.a] = 1'b1;
      end else begin
        m_bad = 1'b1;
      end
    end
    sim_clk = 1'b1;
    repeat (14) begin
      @(negedge clk);
      seen |= update_pulse;
    end
    sim_clk = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= update_pulse;
    end
    check_val({tag, " pulse mask"}, 32'(seen), 32'(exp_mask));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen_busy;
    reset_global = 1'b1;
    sim_clk      = 1'b0;
    wr_stb       = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    clear_status = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    reset_global = 1'b0;
    @(negedge clk);
    check_all("reset");
    check_val("reset pulse", 32'(update_pulse), 32'd0);

    // latency: sim_clk rise sampled at E0, write lands at E3
    host_wr(4'd4, 32'h0000_00C8, 1'b0);
    check_all("queued");
    sim_clk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("lat E2 busy", 32'(busy), 32'd1);
    check_val("lat E2 slot4", param_bus[4*32 +: 32], 32'd0);
    @(negedge clk);
    check_val("lat E3 slot4", param_bus[4*32 +: 32], 32'd200);
    check_val("lat E3 pulse", 32'(update_pulse), 32'h10);
    @(negedge clk);
    check_val("lat E4 pulse", 32'(update_pulse), 32'd0);
    sim_clk = 1'b0;
    repeat (4) @(negedge clk);
    void'(mq.pop_front());
    m_param[4] = 32'd200;
    check_all("lat done");

    for (int i = 0; i < 6; i++) host_wr(AW'(i), 32'(10 + i), 1'b0);
    check_all("six queued");
    do_tick("burst1");
    check_all("burst1");
    do_tick("burst2");
    check_all("burst2");

    for (int i = 0; i < 9; i++) host_wr(AW'(i % NP), $urandom, 1'b0);
    check_all("overflow");
    host_wr(4'd2, 32'h1234, 1'b1);
    check_all("ovf vs clear");
    pulse_clear();
    check_all("ovf cleared");
    do_tick("ovf drain1");
    do_tick("ovf drain2");
    check_all("ovf drained");

    host_wr(4'd12, 32'd5, 1'b0);
    host_wr(4'd1, 32'd7, 1'b0);
    do_tick("badidx");
    check_all("badidx");
    pulse_clear();
    check_all("bad cleared");

    // reset while draining
    host_wr(4'd0, 32'hAAAA, 1'b0);
    host_wr(4'd5, 32'hBBBB, 1'b0);
    host_wr(4'd6, 32'hCCCC, 1'b0);
    sim_clk = 1'b1;
    seen_busy = 1'b0;
    for (int k = 0; k < 10 && !seen_busy; k++) begin
      @(negedge clk);
      seen_busy = busy;
    end
    check_val("busy seen", 32'(seen_busy), 32'd1);
    reset_global = 1'b1;
    sim_clk = 1'b0;
    #1;
    m_reset();
    check_all("mid reset");
    @(negedge clk);
    reset_global = 1'b0;
    repeat (4) @(negedge clk);
    do_tick("post reset");
    check_all("post reset");

    for (int r = 0; r < 20; r++) begin
      int nw;
      nw = $urandom_range(0, 10);
      for (int j = 0; j < nw; j++)
        host_wr(AW'($urandom_range(0, 9)), $urandom, ($urandom_range(0, 7) == 0));
      check_all($sformatf("rnd%0d pre", r));
      do_tick($sformatf("rnd%0d", r));
      check_all($sformatf("rnd%0d post", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
